// File: rtl/utopia_rx_mphy.sv
// Multi-PHY Utopia receive controller: round-robin PHY polling, cell framing
// checks and a cell-granular FIFO that feeds the core as a valid/ready word stream.
module utopia_rx_mphy #(
    parameter  int IfWidth   = 8,
    parameter  int NumPhy    = 4,
    parameter  int FifoDepth = 4,
    localparam int AddrW     = (NumPhy > 1) ? $clog2(NumPhy) : 1,
    localparam int CntW      = $clog2(FifoDepth) + 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [NumPhy-1:0]  phy_clav,
    output logic [AddrW-1:0]   phy_addr,
    output logic               en,
    input  logic [IfWidth-1:0] data,
    input  logic               soc,
    output logic [IfWidth-1:0] out_data,
    output logic               out_soc,
    output logic               out_eoc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CntW-1:0]    cell_cnt,
    output logic               err_frame,
    output logic [7:0]         err_cnt
);

    localparam int CellWords = (IfWidth == 16) ? 27 : 53;
    localparam int SlotW     = $clog2(FifoDepth);
    localparam int MemW      = $clog2(FifoDepth * CellWords);
    localparam logic [5:0]      CELL_N    = 6'(CellWords);
    localparam logic [5:0]      CELL_LAST = 6'(CellWords - 1);
    localparam logic [CntW-1:0] FULL_N    = CntW'(FifoDepth);

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;
    state_t state, state_nxt;

    logic [5:0]         req_cnt, rx_cnt, rd_idx;
    logic [SlotW-1:0]   wr_slot, rd_slot;
    logic [AddrW-1:0]   last_grant, hi_idx, lo_idx, gnt_idx;
    logic               hi_ok, lo_ok, vld_p1;
    logic               grant, word_in, frame_bad, commit, pop, free;
    logic [MemW-1:0]    wr_addr, rd_addr;
    logic [IfWidth-1:0] mem [FifoDepth*CellWords];

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Round robin: lowest requester above last_grant, else lowest overall.
    always_comb begin
        hi_ok  = 1'b0;
        lo_ok  = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NumPhy - 1; j >= 0; j--) begin
            if (phy_clav[j]) begin
                lo_ok  = 1'b1;
                lo_idx = AddrW'(j);
                if (j > int'(last_grant)) begin
                    hi_ok  = 1'b1;
                    hi_idx = AddrW'(j);
                end
            end
        end
    end

    assign gnt_idx   = hi_ok ? hi_idx : lo_idx;
    assign grant     = (state == IDLE) && lo_ok && (cell_cnt < FULL_N);
    assign word_in   = (state == RECV) && vld_p1;
    assign frame_bad = word_in && ((rx_cnt == 6'd0) ? !soc : soc);
    assign commit    = word_in && !frame_bad && (rx_cnt == CELL_LAST);
    assign pop       = out_valid && out_ready;
    assign free      = pop && (rd_idx == CELL_LAST);
    assign wr_addr   = MemW'(int'(wr_slot) * CellWords + int'(rx_cnt));
    assign rd_addr   = MemW'(int'(rd_slot) * CellWords + int'(rd_idx));

    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = RECV;
            RECV:    if (frame_bad) state_nxt = FLUSH;
                     else if (commit) state_nxt = IDLE;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en = (state == RECV) && (req_cnt < CELL_N);
    end

    // p1: bus word requested by last cycle's en is on data/soc now.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            last_grant <= AddrW'(NumPhy - 1);
            phy_addr   <= '0;
            req_cnt    <= '0;
            rx_cnt     <= '0;
            wr_slot    <= '0;
            rd_slot    <= '0;
            rd_idx     <= '0;
            cell_cnt   <= '0;
            err_frame  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            vld_p1    <= en;
            err_frame <= frame_bad;
            if (frame_bad) err_cnt <= sat_inc8(err_cnt);
            if (grant) begin
                phy_addr   <= gnt_idx;
                last_grant <= gnt_idx;
                req_cnt    <= '0;
                rx_cnt     <= '0;
            end else begin
                if (en) req_cnt <= req_cnt + 6'd1;
                if (word_in && !frame_bad) rx_cnt <= rx_cnt + 6'd1;
            end
            if (commit) wr_slot <= wr_slot + 1'b1;
            if (pop) begin
                if (free) begin
                    rd_idx  <= '0;
                    rd_slot <= rd_slot + 1'b1;
                end else begin
                    rd_idx <= rd_idx + 6'd1;
                end
            end
            case ({commit, free})
                2'b10:   cell_cnt <= cell_cnt + CntW'(1);
                2'b01:   cell_cnt <= cell_cnt - CntW'(1);
                default: cell_cnt <= cell_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (word_in && !frame_bad) mem[wr_addr] <= data;
    end

    assign out_valid = (cell_cnt != '0);
    assign out_data  = out_valid ? mem[rd_addr] : '0;
    assign out_soc   = out_valid && (rd_idx == 6'd0);
    assign out_eoc   = out_valid && (rd_idx == CELL_LAST);

endmodule

// File: tb/tb_utopia_rx_mphy.sv
// Scoreboard bench for utopia_rx_mphy: an 8-bit/4-PHY and a 16-bit/2-PHY instance
// fed by behavioural PHYs; expected cells are queued when each PHY starts a cell.
module tb_utopia_rx_mphy;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       reset8, en8, soc8, osoc8, oeoc8, ovld8, ordy8, ferr8;
    logic [3:0] clav8;
    logic [1:0] addr8;
    logic [7:0] data8, od8, ecnt8;
    logic [2:0] cnt8;

    logic        reset16, en16, soc16, osoc16, oeoc16, ovld16, ordy16, ferr16;
    logic [1:0]  clav16, cnt16;
    logic [0:0]  addr16;
    logic [15:0] data16, od16;
    logic [7:0]  ecnt16;

    utopia_rx_mphy #(.IfWidth(8), .NumPhy(4), .FifoDepth(4)) u8 (
        .clk_in(clk_in), .reset(reset8), .phy_clav(clav8), .phy_addr(addr8), .en(en8),
        .data(data8), .soc(soc8), .out_data(od8), .out_soc(osoc8), .out_eoc(oeoc8),
        .out_valid(ovld8), .out_ready(ordy8), .cell_cnt(cnt8), .err_frame(ferr8),
        .err_cnt(ecnt8));

    utopia_rx_mphy #(.IfWidth(16), .NumPhy(2), .FifoDepth(2)) u16 (
        .clk_in(clk_in), .reset(reset16), .phy_clav(clav16), .phy_addr(addr16), .en(en16),
        .data(data16), .soc(soc16), .out_data(od16), .out_soc(osoc16), .out_eoc(oeoc16),
        .out_valid(ovld16), .out_ready(ordy16), .cell_cnt(cnt16), .err_frame(ferr16),
        .err_cnt(ecnt16));

    typedef logic [17:0] exp_t;  // {soc, eoc, data[15:0]}
    exp_t q8[$], q16[$];
    int   gnt8[$];
    int   n_vec = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // PHY models: a word is driven during the cycle after each en cycle.
    logic seen8 = 1'b0, seen16 = 1'b0;
    int   k8 = 0, runt8 = -1, cur_runt8 = -1, cells8 = 0, base8 = 0;
    int   k16 = 0, cells16 = 0, base16 = 0;

    always @(negedge clk_in) begin
        if (seen8) begin
            data8 = 8'(k8 + base8 * 16);
            soc8  = ((k8 == 0) != (k8 == cur_runt8));
            k8++;
        end else begin
            data8 = 8'hA5;
            soc8  = 1'b0;
        end
        if (en8 && !seen8) begin
            k8        = 0;
            cur_runt8 = runt8;
            base8     = cells8;
            cells8++;
            gnt8.push_back(int'(addr8));
            if (cur_runt8 < 0)
                for (int i = 0; i < 53; i++)
                    q8.push_back({(i == 0), (i == 52), 8'h00, 8'(i + base8 * 16)});
        end
        seen8 = en8;
    end

    always @(negedge clk_in) begin
        if (seen16) begin
            data16 = {8'(k16), 8'(base16)};
            soc16  = (k16 == 0);
            k16++;
        end else begin
            data16 = 16'hA5A5;
            soc16  = 1'b0;
        end
        if (en16 && !seen16) begin
            k16    = 0;
            base16 = cells16;
            cells16++;
            for (int i = 0; i < 27; i++)
                q16.push_back({(i == 0), (i == 26), 8'(i), 8'(base16)});
        end
        seen16 = en16;
    end

    // Monitors: every accepted output word is matched against the queue head.
    exp_t e8, e16;
    always @(negedge clk_in) begin
        if (ovld8 && ordy8) begin
            if (q8.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL out8_extra: got word %0h expected none", od8);
            end else begin
                e8 = q8.pop_front();
                chk("out8_word", {14'd0, osoc8, oeoc8, 8'h00, od8}, {14'd0, e8});
            end
        end
        if (ovld16 && ordy16) begin
            if (q16.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL out16_extra: got word %0h expected none", od16);
            end else begin
                e16 = q16.pop_front();
                chk("out16_word", {14'd0, osoc16, oeoc16, od16}, {14'd0, e16});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        reset8 = 1'b1; clav8 = '0; ordy8 = 1'b0; data8 = '0; soc8 = 1'b0;
        reset16 = 1'b1; clav16 = '0; ordy16 = 1'b0; data16 = '0; soc16 = 1'b0;
        repeat (3) tick();

        chk("rst_en", en8, 0);
        chk("rst_addr", addr8, 0);
        chk("rst_valid", ovld8, 0);
        chk("rst_soc_eoc", {osoc8, oeoc8}, 0);
        chk("rst_data", od8, 0);
        chk("rst_cnt", cnt8, 0);
        chk("rst_err", {ferr8, ecnt8}, 0);

        // One well-formed cell from PHY2.
        reset8 = 1'b0; ordy8 = 1'b1; clav8 = 4'b0100;
        for (int i = 0; i < 10 && !en8; i++) tick();
        chk("t1_grant_en", en8, 1);
        chk("t1_addr", addr8, 2);
        clav8 = '0;
        c = 0;
        while (en8 && c < 100) begin c++; tick(); end
        chk("t1_en_cycles", c, 53);
        for (int i = 0; i < 5 && cnt8 != 3'd1; i++) tick();
        chk("t1_cnt_one", cnt8, 1);
        for (int i = 0; i < 60 && cnt8 != 3'd0; i++) tick();
        chk("t1_cnt_zero", cnt8, 0);

        // Round robin over four requesting PHYs.
        reset8 = 1'b1; tick(); reset8 = 1'b0;
        gnt8.delete();
        clav8 = 4'hF;
        for (int i = 0; i < 600 && gnt8.size() < 8; i++) tick();
        clav8 = '0;
        chk("rr_count", gnt8.size(), 8);
        for (int i = 0; i < 8 && i < gnt8.size(); i++) chk("rr_order", gnt8[i], i % 4);
        repeat (130) tick();
        chk("rr_drained", cnt8, 0);

        // Backpressure: buffer fills at four cells, then one drains.
        reset8 = 1'b1; tick(); reset8 = 1'b0;
        gnt8.delete();
        ordy8 = 1'b0; clav8 = 4'hF;
        for (int i = 0; i < 300 && cnt8 != 3'd4; i++) tick();
        chk("bp_full", cnt8, 4);
        c = 0;
        for (int i = 0; i < 60; i++) begin c += int'(en8); tick(); end
        chk("bp_en_idle", c, 0);
        chk("bp_grants", gnt8.size(), 4);
        ordy8 = 1'b1;
        for (int i = 0; i < 60 && cnt8 != 3'd3; i++) tick();
        chk("bp_cnt3", cnt8, 3);
        tick();
        chk("bp_5th_en", en8, 1);
        tick();
        clav8 = '0;
        chk("bp_5th_grants", gnt8.size(), 5);
        if (gnt8.size() == 5) chk("bp_5th_phy", gnt8[4], 0);
        for (int i = 0; i < 400 && cnt8 != 3'd0; i++) tick();
        chk("bp_drained", cnt8, 0);

        // Runt cell: soc on word 20, then a clean cell from the same PHY.
        clav8 = 4'b0010; runt8 = 20;
        for (int i = 0; i < 10 && !en8; i++) tick();
        tick();
        runt8 = -1;
        for (int i = 0; i < 40 && !ferr8; i++) tick();
        chk("runt_pulse", ferr8, 1);
        chk("runt_errcnt", ecnt8, 1);
        chk("runt_cnt", cnt8, 0);
        tick();
        chk("runt_pulse_end", {ferr8, en8}, 0);
        tick();
        chk("runt_regrant", en8, 1);
        chk("runt_addr", addr8, 1);
        tick();
        clav8 = '0;
        for (int i = 0; i < 70 && cnt8 != 3'd1; i++) tick();
        chk("runt_next_cell", cnt8, 1);
        for (int i = 0; i < 60 && cnt8 != 3'd0; i++) tick();

        // Missing soc on word 0.
        clav8 = 4'b0001; runt8 = 0;
        for (int i = 0; i < 10 && !en8; i++) tick();
        tick();
        runt8 = -1; clav8 = '0;
        for (int i = 0; i < 10 && !ferr8; i++) tick();
        chk("nosoc_pulse", ferr8, 1);
        chk("nosoc_errcnt", ecnt8, 2);
        chk("nosoc_cnt", cnt8, 0);

        // Reset in the middle of a cell with one committed cell held.
        ordy8 = 1'b0; clav8 = 4'b1000;
        for (int i = 0; i < 70 && cnt8 != 3'd1; i++) tick();
        for (int i = 0; i < 10 && !en8; i++) tick();
        repeat (11) tick();
        reset8 = 1'b1;
        tick();
        q8.delete();
        chk("mid_en", en8, 0);
        chk("mid_cnt", cnt8, 0);
        chk("mid_valid", ovld8, 0);
        chk("mid_errcnt", ecnt8, 0);
        chk("mid_errpulse", ferr8, 0);
        clav8 = 4'b0110; reset8 = 1'b0; ordy8 = 1'b1;
        for (int i = 0; i < 10 && !en8; i++) tick();
        chk("mid_regrant", en8, 1);
        chk("mid_lowest", addr8, 1);
        tick();
        clav8 = '0;
        repeat (130) tick();
        chk("mid_drained", cnt8, 0);

        // 16-bit bus: commit and eoc pop land on the same edge.
        reset16 = 1'b0; clav16 = 2'b01;
        for (int i = 0; i < 40 && cnt16 != 2'd1; i++) tick();
        chk("w16_first", cnt16, 1);
        for (int i = 0; i < 10 && !en16; i++) tick();
        chk("w16_second_en", en16, 1);
        tick();
        ordy16 = 1'b1; clav16 = '0;
        for (int i = 0; i < 40 && !(ovld16 && oeoc16); i++) tick();
        chk("w16_eoc_seen", oeoc16, 1);
        chk("w16_cnt_pre", cnt16, 1);
        tick();
        chk("w16_cnt_post", cnt16, 1);
        chk("w16_next_soc", {ovld16, osoc16}, 2'b11);
        repeat (40) tick();
        chk("w16_drained", cnt16, 0);

        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/utopia_rx_mphy.md
# utopia_rx_mphy

Parametrised multi-PHY Utopia receive controller. It round-robin polls up to NumPhy PHY cell-available lines and drives the enable handshake to pull one complete ATM cell at a time over an 8- or 16-bit Utopia bus. It checks cell framing and buffers whole cells in a cell-granular FIFO. Cells are presented to the switch core as a word stream with valid/ready. It sits between the PHY-side Utopia receive bus and the core receive path.

## Interface
- IfWidth, 8, Utopia data width; legal values 8 or 16.
- NumPhy, 4, number of polled PHYs, 1..16.
- FifoDepth, 4, cell slots in buffer, power of two, 2..8.
- Derived: CellWords = 53 (IfWidth=8) or 27 (IfWidth=16, last word low byte is pad); AddrW = max(1,clog2(NumPhy)).

Ports:
- clk_in  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- phy_clav  in  NumPhy  per-PHY cell available (direct status).
- phy_addr  out  AddrW  selected PHY.
- en  out  1  read enable to selected PHY, active-high.
- data  in  IfWidth  Utopia data, valid the cycle after a cycle with en=1.
- soc  in  1  start of cell, qualified like data.
- out_data  out  IfWidth  cell word to core.
- out_soc  out  1  first word of cell.
- out_eoc  out  1  last word of cell.
- out_valid  out  1  word available.
- out_ready  in  1  core accepts word.
- cell_cnt  out  clog2(FifoDepth)+1  committed cells held.
- err_frame  out  1  one-cycle pulse per discarded cell.
- err_cnt  out  8  saturating count of discarded cells.

## Operation
- States: IDLE, RECV, FLUSH.
- IDLE: if cell_cnt < FifoDepth and any phy_clav set, grant the first set bit searching upward (wrapping) from last_grant+1; load phy_addr, clear counters, go RECV. No grant if buffer full; phy_clav is ignored.
- RECV: en=1 while req_cnt < CellWords; req_cnt increments per en cycle. Sampled words (those arriving one cycle after an en cycle) are written to the current slot at index rx_cnt, and rx_cnt increments.
- Framing: word 0 must have soc=1; any later word with soc=1 is a runt. Either violation: drop en, discard the partial cell (slot not committed), pulse err_frame, increment err_cnt (saturate at 255), go FLUSH.
- Completion: when rx_cnt reaches CellWords, commit the slot (write slot pointer advances, cell_cnt +1) and go IDLE. en is already 0 because req_cnt==CellWords.
- FLUSH: one cycle; any in-flight word is ignored; then go IDLE.
- Output: out_valid=1 while cell_cnt>0. Words are read from the head slot at read index. A transfer happens when out_valid&out_ready. out_soc = (index==0); out_eoc = (index==CellWords-1). A transfer on the eoc word frees the slot (cell_cnt -1).
- Commit and free in the same cycle: cell_cnt unchanged.
- Pointers wrap modulo FifoDepth. Only committed slots are readable.
- phy_addr holds its value outside RECV.
- Reset: the FIFO is emptied, state goes to IDLE, and last_grant=NumPhy-1, so the first grant is the lowest set PHY starting at PHY0. Reset mid-cell abandons the cell without an err_frame pulse.

## Timing
- Reset values: en=0, phy_addr=0, out_valid=0, out_soc=0, out_eoc=0, out_data=0, cell_cnt=0, err_frame=0, err_cnt=0.
- clav seen in IDLE at cycle t: phy_addr and en=1 from t+1. en is high for cycles t+1..t+CellWords. Words are sampled t+2..t+1+CellWords. Commit is on the edge ending t+1+CellWords, and out_valid is high from t+2+CellWords if the buffer was empty.
- Minimum inter-cell gap: one IDLE cycle. A cell needs CellWords+2 cycles.
- out_data/out_soc/out_eoc are stable while out_valid=1 and out_ready=0.
- Back-to-back output: one word per cycle with out_ready held high.

## Test plan
- IfWidth=8, PHY2 only clav, one well-formed cell 0x00..0x34 → en high 53 cycles at phy_addr=2; core receives 53 words with out_soc on 0x00 and out_eoc on 0x34; cell_cnt 1→0.
- All four clav high, 8 cells → grants follow 0,1,2,3,0,1,2,3.
- out_ready=0, FifoDepth=4, clav held → exactly 4 cells accepted, then en stays 0. Raising out_ready drains one cell; a fifth grant follows within 1 cycle of cell_cnt falling to 3.
- Runt: soc asserted on word 20 → err_frame one pulse, err_cnt=1, cell_cnt unchanged, FLUSH then a new grant. Missing soc on word 0 behaves the same.
- IfWidth=16: 27 words per cell, out_eoc on word 26. Commit and eoc pop in the same cycle leave cell_cnt unchanged.
- Reset asserted at rx_cnt=10 → next cycle en=0, cell_cnt=0, out_valid=0, err_cnt=0; the next grant is the lowest set PHY.
